// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: shared comparator op encodings and branch constants
package branch_resolve_pkg;
  localparam int CMP_OP_WIDTH = 3;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_OP_BEQ  = 3'd0;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_OP_BNE  = 3'd1;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_OP_BLT  = 3'd4;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_OP_BGE  = 3'd5;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_OP_BLTU = 3'd6;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_OP_BGEU = 3'd7;
  localparam int BR_INSN_BYTES = 4;
endpackage

// File: rtl/branch_resolve_cmp.sv
// cmp: branch condition comparator; unknown ops report not taken
//   i_op/i_src1/i_src2 -> o_taken
module cmp
  import branch_resolve_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [CMP_OP_WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0]        i_src1,
  input  logic [WIDTH-1:0]        i_src2,
  output logic                    o_taken
);
  logic eq, lt, ltu;
  always_comb begin
    eq  = i_src1 == i_src2;
    lt  = $signed(i_src1) < $signed(i_src2);
    ltu = i_src1 < i_src2;
    o_taken = i_op == CMP_OP_BEQ  ? eq   :
              i_op == CMP_OP_BNE  ? !eq  :
              i_op == CMP_OP_BLT  ? lt   :
              i_op == CMP_OP_BGE  ? !lt  :
              i_op == CMP_OP_BLTU ? ltu  :
              i_op == CMP_OP_BGEU ? !ltu : 1'b0;
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution with redirect and perf counters
//   upstream: i_valid/o_ready, i_op, i_src1, i_src2, i_pc, i_imm, i_pred_taken, i_flush
//   downstream: o_valid/i_ready, o_taken, o_redirect, o_redirect_pc, o_misaligned
//   counters: o_br_cnt, o_mis_cnt
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [CMP_OP_WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0]        i_src1,
  input  logic [WIDTH-1:0]        i_src2,
  input  logic [WIDTH-1:0]        i_pc,
  input  logic [WIDTH-1:0]        i_imm,
  input  logic                    i_pred_taken,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_taken,
  output logic                    o_redirect,
  output logic [WIDTH-1:0]        o_redirect_pc,
  output logic                    o_misaligned,
  output logic [CNT_WIDTH-1:0]    o_br_cnt,
  output logic [CNT_WIDTH-1:0]    o_mis_cnt
);
  logic             taken, mis, misal, accept;
  logic [WIDTH-1:0] target, fallthrough, next_pc;
  cmp #(.WIDTH(WIDTH)) u_cmp (
    .i_op   (i_op),
    .i_src1 (i_src1),
    .i_src2 (i_src2),
    .o_taken(taken)
  );
  always_comb begin
    o_ready     = !o_valid || i_ready;
    accept      = i_valid && o_ready && !i_flush;
    target      = i_pc + i_imm;
    fallthrough = i_pc + WIDTH'(BR_INSN_BYTES);
    next_pc     = taken ? target : fallthrough;
    mis         = taken ^ i_pred_taken;
    misal       = taken && (target[1:0] != 2'b00);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_taken       <= 1'b0;
      o_redirect    <= 1'b0;
      o_misaligned  <= 1'b0;
      o_redirect_pc <= '0;
      o_br_cnt      <= '0;
      o_mis_cnt     <= '0;
    end else if (accept) begin
      o_valid       <= 1'b1;
      o_taken       <= taken;
      o_redirect_pc <= next_pc;
      o_misaligned  <= misal;
      // a misaligned target takes the exception path instead of redirecting
      o_redirect    <= mis && !misal;
      o_br_cnt      <= o_br_cnt + CNT_WIDTH'(1);
      o_mis_cnt     <= o_mis_cnt + CNT_WIDTH'(mis);
    end else if (i_flush || (o_valid && i_ready)) begin
      o_valid       <= 1'b0;
      o_redirect    <= 1'b0;
      o_misaligned  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed self-checking bench for branch_resolve
module tb_branch_resolve;
  import branch_resolve_pkg::*;
  logic                    i_clk = 1'b0;
  logic                    i_rst, i_valid, i_pred_taken, i_flush, i_ready;
  logic [CMP_OP_WIDTH-1:0] i_op;
  logic [31:0]             i_src1, i_src2, i_pc, i_imm;
  logic                    o_ready, o_valid, o_taken, o_redirect, o_misaligned;
  logic [31:0]             o_redirect_pc, o_br_cnt, o_mis_cnt;
  int checks = 0;
  int fails  = 0;
  branch_resolve #(.WIDTH(32), .CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_src1(i_src1), .i_src2(i_src2), .i_pc(i_pc), .i_imm(i_imm),
    .i_pred_taken(i_pred_taken), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_taken(o_taken), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_misaligned(o_misaligned),
    .o_br_cnt(o_br_cnt), .o_mis_cnt(o_mis_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    i_valid = 1'b1; i_op = op; i_src1 = s1; i_src2 = s2; i_pc = pc; i_imm = imm; i_pred_taken = pred;
  endtask
  task automatic expect_out(input string tag, input logic v, input logic t, input logic r,
                            input logic [31:0] pc, input logic m, input int br, input int mc);
    check({tag, ".valid"}, 64'(o_valid), 64'(v));
    check({tag, ".taken"}, 64'(o_taken), 64'(t));
    check({tag, ".redirect"}, 64'(o_redirect), 64'(r));
    check({tag, ".pc"}, 64'(o_redirect_pc), 64'(pc));
    check({tag, ".misal"}, 64'(o_misaligned), 64'(m));
    check({tag, ".br_cnt"}, 64'(o_br_cnt), 64'(br));
    check({tag, ".mis_cnt"}, 64'(o_mis_cnt), 64'(mc));
  endtask
  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    drive(CMP_OP_BEQ, 0, 0, 0, 0, 1'b0);
    i_valid = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    expect_out("reset", 0, 0, 0, 32'h0, 0, 0, 0);
    check("reset.ready", 64'(o_ready), 64'd1);
    drive(CMP_OP_BEQ, 32'd13, 32'd13, 32'h100, 32'h20, 1'b1);
    tick();
    expect_out("beq", 1, 1, 0, 32'h120, 0, 1, 0);
    drive(CMP_OP_BLT, -32'sd22, 32'd2, 32'h200, -32'sd8, 1'b0);
    tick();
    expect_out("blt", 1, 1, 1, 32'h1F8, 0, 2, 1);
    drive(CMP_OP_BLTU, -32'sd12, 32'd10, 32'hFFFF_FFFC, 32'h10, 1'b1);
    tick();
    expect_out("bltu_wrap", 1, 0, 1, 32'h0, 0, 3, 2);
    i_ready = 1'b0;
    drive(CMP_OP_BNE, 32'd13, 32'd11, 32'h300, 32'h40, 1'b1);
    #1;
    check("bp.ready", 64'(o_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.ready_hold", 64'(o_ready), 64'd0);
      expect_out("bp.hold", 1, 0, 1, 32'h0, 0, 3, 2);
    end
    i_ready = 1'b1;
    #1;
    check("bp.release_ready", 64'(o_ready), 64'd1);
    tick();
    expect_out("bp.accept", 1, 1, 0, 32'h340, 0, 4, 2);
    i_valid = 1'b0;
    tick();
    expect_out("drain", 0, 1, 0, 32'h340, 0, 4, 2);
    drive(CMP_OP_BEQ, 32'd1, 32'd1, 32'h400, 32'h8, 1'b0);
    tick();
    expect_out("pre_flush", 1, 1, 1, 32'h408, 0, 5, 3);
    i_ready = 1'b0; i_flush = 1'b1;
    drive(CMP_OP_BNE, 32'd13, 32'd11, 32'h500, 32'h10, 1'b0);
    tick();
    expect_out("flush", 0, 1, 0, 32'h408, 0, 5, 3);
    i_flush = 1'b0; i_ready = 1'b1;
    drive(CMP_OP_BGE, 32'd12, 32'd2, 32'h100, 32'h6, 1'b0);
    tick();
    expect_out("misal", 1, 1, 0, 32'h106, 1, 6, 4);
    drive(3'd2, 32'd7, 32'd7, 32'h100, 32'h20, 1'b1);
    tick();
    expect_out("unknown_op", 1, 0, 1, 32'h104, 0, 7, 5);
    drive(CMP_OP_BEQ, 32'd3, 32'd3, 32'h600, 32'h10, 1'b0);
    i_rst = 1'b1;
    tick();
    expect_out("rst_mid", 0, 0, 0, 32'h0, 0, 0, 0);
    tick();
    expect_out("rst_hold", 0, 0, 0, 32'h0, 0, 0, 0);
    i_rst = 1'b0; i_valid = 1'b0;
    tick();
    expect_out("post_rst", 0, 0, 0, 32'h0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
